// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory with byte/halfword store merge and write log
// Optional: define DM_ALIGN_CHECK_EN to suppress misaligned stores and raise sticky align_err.
module data_mem #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic [1:0]  SOp,
    output logic [31:0] RD,
    output logic        align_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH] = '{default: 32'h0};
    logic [ADDR_W-1:0] idx;
    logic [31:0]       merged;
    logic              misaligned;
    logic              do_write;
    logic              unused_hi;

    // Upper address bits wrap: they select nothing.
    assign idx       = A[ADDR_W+1:2];
    assign unused_hi = &{1'b0, A[31:ADDR_W+2]};
    assign RD        = mem[idx];

    // Partial stores merge into the currently addressed word in the same cycle.
    always_comb begin
        merged = RD;
        case (SOp)
            2'b00: merged = WD;
            2'b01: begin
                if (A[1]) merged[31:16] = WD[15:0];
                else      merged[15:0]  = WD[15:0];
            end
            2'b10: merged[{A[1:0], 3'b000} +: 8] = WD[7:0];
            default: merged = RD;
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    assign misaligned = ((SOp == 2'b00) && (A[1:0] != 2'b00)) ||
                        ((SOp == 2'b01) && A[0]);

    always_ff @(posedge clk) begin
        if (reset)
            align_err <= 1'b0;
        else if (MemWrite && misaligned)
            align_err <= 1'b1;
    end
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    assign do_write = MemWrite && (SOp != 2'b11) && !misaligned;

    // Reset wins over a simultaneous store.
    always_ff @(posedge clk) begin
        if (reset)
            mem <= '{default: 32'h0};
        else if (do_write)
            mem[idx] <= merged;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && do_write)
            $display("@%h: *%h <= %h", PC, {A[31:2], 2'b00}, merged);
    end
`endif

endmodule
